rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Five-agent round-robin arbiter with a mandatory one-cycle gap between tenures.
// Optional hold limit (MAX_HOLD cycles per tenure) is enabled by defining RR_HOLD_TIMEOUT_EN.
module rr_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] req,
  output logic [4:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] ptr_r;
  logic [2:0] ptr_nxt_s;
  logic [2:0] win_s;
  logic [2:0] gnt_id_r;
  logic [2:0] gnt_id_nxt_s;
  logic [4:0] gnt_r;
  logic [4:0] gnt_nxt_s;
  logic       busy_r;
  logic       busy_nxt_s;
  logic       any_req_s;
  logic       held_s;
  logic       limit_s;

  if ((MAX_HOLD < 32'sd1) || (MAX_HOLD > 32'sd255)) begin : g_max_hold_range
    $error("rr_arbiter: MAX_HOLD must be within 1..255");
  end

  // Rotate so that bit 0 of the result is the request of agent p.
  function automatic logic [4:0] rotate_req(input logic [4:0] r, input logic [2:0] p);
    case (p)
      3'd0:    rotate_req = r;
      3'd1:    rotate_req = {r[0],   r[4:1]};
      3'd2:    rotate_req = {r[1:0], r[4:2]};
      3'd3:    rotate_req = {r[2:0], r[4:3]};
      3'd4:    rotate_req = {r[3:0], r[4]};
      default: rotate_req = r;
    endcase
  endfunction

  function automatic logic [2:0] first_offset(input logic [4:0] rot);
    if (rot[0])      first_offset = 3'd0;
    else if (rot[1]) first_offset = 3'd1;
    else if (rot[2]) first_offset = 3'd2;
    else if (rot[3]) first_offset = 3'd3;
    else if (rot[4]) first_offset = 3'd4;
    else             first_offset = 3'd0;
  endfunction

  function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (sum)
      4'd5:    add_mod5 = 3'd0;
      4'd6:    add_mod5 = 3'd1;
      4'd7:    add_mod5 = 3'd2;
      4'd8:    add_mod5 = 3'd3;
      default: add_mod5 = sum[2:0];
    endcase
  endfunction

  assign any_req_s = |req;
  assign win_s     = add_mod5(ptr_r, first_offset(rotate_req(req, ptr_r)));
  // gnt_r is one-hot while granting, so this is req[gnt_id] without an out-of-range index
  assign held_s    = |(req & gnt_r);

`ifdef RR_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  logic [7:0] hold_r;
  logic [7:0] hold_nxt_s;
  logic       timeout_r;
  logic       timeout_nxt_s;
  assign limit_s = (hold_r == HOLD_LIMIT);
  assign timeout = timeout_r;
`else
  assign limit_s = 1'b0;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a release wins over the hold limit in the same cycle.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (any_req_s) state_nxt_s = ST_GRANT;
        else           state_nxt_s = ST_IDLE;
      end
      ST_GRANT: begin
        if (!held_s)      state_nxt_s = ST_GAP;
        else if (limit_s) state_nxt_s = ST_GAP;
        else              state_nxt_s = ST_GRANT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    gnt_nxt_s    = 5'b00000;
    gnt_id_nxt_s = gnt_id_r;
    busy_nxt_s   = 1'b0;
    ptr_nxt_s    = ptr_r;
`ifdef RR_HOLD_TIMEOUT_EN
    hold_nxt_s    = hold_r;
    timeout_nxt_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (any_req_s) begin
          gnt_nxt_s    = 5'b00001 << win_s;
          gnt_id_nxt_s = win_s;
          busy_nxt_s   = 1'b1;
          ptr_nxt_s    = add_mod5(win_s, 3'd1);
`ifdef RR_HOLD_TIMEOUT_EN
          hold_nxt_s   = 8'd1;
`endif
        end else begin
          gnt_nxt_s    = 5'b00000;
        end
      end
      ST_GRANT: begin
        if (held_s && !limit_s) begin
          gnt_nxt_s  = gnt_r;
          busy_nxt_s = 1'b1;
`ifdef RR_HOLD_TIMEOUT_EN
          if (hold_r != 8'hFF) hold_nxt_s = hold_r + 8'd1;
          else                 hold_nxt_s = hold_r;
`endif
        end else begin
          gnt_nxt_s     = 5'b00000;
`ifdef RR_HOLD_TIMEOUT_EN
          hold_nxt_s    = 8'd0;
          timeout_nxt_s = held_s;
`endif
        end
      end
      default: gnt_nxt_s = 5'b00000;
    endcase
  end

  // Output, pointer and hold-counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_r     <= 5'b00000;
      gnt_id_r  <= 3'd0;
      busy_r    <= 1'b0;
      ptr_r     <= 3'd0;
`ifdef RR_HOLD_TIMEOUT_EN
      hold_r    <= 8'd0;
      timeout_r <= 1'b0;
`endif
    end else begin
      gnt_r     <= gnt_nxt_s;
      gnt_id_r  <= gnt_id_nxt_s;
      busy_r    <= busy_nxt_s;
      ptr_r     <= ptr_nxt_s;
`ifdef RR_HOLD_TIMEOUT_EN
      hold_r    <= hold_nxt_s;
      timeout_r <= timeout_nxt_s;
`endif
    end
  end

  assign gnt    = gnt_r;
  assign gnt_id = gnt_id_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (MAX_HOLD=4); hold-limit checks run when RR_HOLD_TIMEOUT_EN is defined.
module tb_rr_arbiter;

  logic       clock;
  logic       reset;
  logic [4:0] req;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter #(.MAX_HOLD(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 5'b00000;
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== 10'b0) begin
      $display("FAIL reset_async: got gnt=%b id=%0d busy=%b to=%b, want all zero", gnt, gnt_id, busy, timeout);
      errors++;
    end
    req = 5'b11111;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== 10'b0) begin
      $display("FAIL reset_held: got gnt=%b id=%0d busy=%b to=%b, want all zero", gnt, gnt_id, busy, timeout);
      errors++;
    end
    reset = 1'b0;
    req   = 5'b00001;
  endtask

  task automatic test_first_grant();
    tick();
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== {5'b00001, 3'd0, 1'b1, 1'b0}) begin
      $display("FAIL first_grant: got gnt=%b id=%0d busy=%b to=%b, want gnt=00001 id=0 busy=1 to=0", gnt, gnt_id, busy, timeout);
      errors++;
    end
    req = 5'b00000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({gnt, busy, timeout} !== 7'b0) begin
        $display("FAIL first_release[%0d]: got gnt=%b busy=%b to=%b, want 0", i, gnt, busy, timeout);
        errors++;
      end
    end
  endtask

  // ptr=1: agent 1 holds against agent 2, then gaps are forced between tenures 1->2->3.
  task automatic test_back_to_back();
    logic [4:0] req_v [6]  = '{5'b00110, 5'b00110, 5'b00100, 5'b00100, 5'b01000, 5'b01000};
    logic [4:0] gnt_v [6]  = '{5'b00010, 5'b00010, 5'b00000, 5'b00100, 5'b00000, 5'b01000};
    logic [2:0] id_v  [6]  = '{3'd1, 3'd1, 3'd0, 3'd2, 3'd0, 3'd3};
    for (int i = 0; i < 6; i++) begin
      req = req_v[i];
      tick();
      checks++;
      if ((gnt !== gnt_v[i]) || (busy !== (gnt_v[i] != 5'b0)) || (timeout !== 1'b0) ||
          ((gnt_v[i] != 5'b0) && (gnt_id !== id_v[i]))) begin
        $display("FAIL back_to_back[%0d]: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d to=0",
                 i, gnt, gnt_id, busy, timeout, gnt_v[i], id_v[i]);
        errors++;
      end
    end
  endtask

  // Agent 3 holds (ptr=4); 5'b10001 must pick agent 4 first, then agent 0.
  task automatic test_wrap();
    logic [4:0] req_v [6]  = '{5'b10001, 5'b10001, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    logic [4:0] gnt_v [6]  = '{5'b00000, 5'b10000, 5'b00000, 5'b00001, 5'b00000, 5'b00000};
    logic [2:0] id_v  [6]  = '{3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 6; i++) begin
      req = req_v[i];
      tick();
      checks++;
      if ((gnt !== gnt_v[i]) || (busy !== (gnt_v[i] != 5'b0)) || (timeout !== 1'b0) ||
          ((gnt_v[i] != 5'b0) && (gnt_id !== id_v[i]))) begin
        $display("FAIL wrap[%0d]: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d to=0",
                 i, gnt, gnt_id, busy, timeout, gnt_v[i], id_v[i]);
        errors++;
      end
    end
  endtask

  task automatic test_release();
    req = 5'b00100;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({gnt, gnt_id, busy, timeout} !== {5'b00100, 3'd2, 1'b1, 1'b0}) begin
        $display("FAIL release_grant[%0d]: got gnt=%b id=%0d busy=%b to=%b, want gnt=00100 id=2 busy=1 to=0", i, gnt, gnt_id, busy, timeout);
        errors++;
      end
    end
    req = 5'b00000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({gnt, busy, timeout} !== 7'b0) begin
        $display("FAIL release_gap_idle[%0d]: got gnt=%b busy=%b to=%b, want 0", i, gnt, busy, timeout);
        errors++;
      end
    end
  endtask

  task automatic test_async_reset();
    req = 5'b01000;
    tick();
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== {5'b01000, 3'd3, 1'b1, 1'b0}) begin
      $display("FAIL areset_pre: got gnt=%b id=%0d busy=%b to=%b, want gnt=01000 id=3 busy=1 to=0", gnt, gnt_id, busy, timeout);
      errors++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== 10'b0) begin
      $display("FAIL areset_midcycle: got gnt=%b id=%0d busy=%b to=%b, want all zero", gnt, gnt_id, busy, timeout);
      errors++;
    end
    tick();
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== 10'b0) begin
      $display("FAIL areset_edge: got gnt=%b id=%0d busy=%b to=%b, want all zero", gnt, gnt_id, busy, timeout);
      errors++;
    end
    reset = 1'b0;
    req   = 5'b01010;
    tick();
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== {5'b00010, 3'd1, 1'b1, 1'b0}) begin
      $display("FAIL areset_after: got gnt=%b id=%0d busy=%b to=%b, want gnt=00010 id=1 busy=1 to=0", gnt, gnt_id, busy, timeout);
      errors++;
    end
    req = 5'b00000;
    repeat (2) tick();
  endtask

`ifdef RR_HOLD_TIMEOUT_EN
  task automatic test_timeout();
    logic [4:0] exp_gnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = 5'b00001 << (k % 5);
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if ({gnt, gnt_id, busy, timeout} !== {exp_gnt, 3'(k % 5), 1'b1, 1'b0}) begin
          $display("FAIL timeout_grant[%0d.%0d]: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=1 to=0",
                   k, c, gnt, gnt_id, busy, timeout, exp_gnt, k % 5);
          errors++;
        end
      end
      tick();
      checks++;
      if ({gnt, busy, timeout} !== {5'b00000, 1'b0, 1'b1}) begin
        $display("FAIL timeout_gap[%0d]: got gnt=%b busy=%b to=%b, want gnt=00000 busy=0 to=1", k, gnt, busy, timeout);
        errors++;
      end
    end
    // Release coinciding with the hold limit is a plain release.
    req = 5'b00010;
    repeat (4) tick();
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== {5'b00010, 3'd1, 1'b1, 1'b0}) begin
      $display("FAIL limit_release_grant: got gnt=%b id=%0d busy=%b to=%b, want gnt=00010 id=1 busy=1 to=0", gnt, gnt_id, busy, timeout);
      errors++;
    end
    req = 5'b00000;
    tick();
    checks++;
    if ({gnt, busy, timeout} !== 7'b0) begin
      $display("FAIL limit_release_gap: got gnt=%b busy=%b to=%b, want gnt=00000 busy=0 to=0", gnt, busy, timeout);
      errors++;
    end
  endtask
`else
  task automatic test_no_timeout();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 5'b00001;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ((gnt !== 5'b00001) || (timeout !== 1'b0)) begin
        $display("FAIL no_timeout[%0d]: got gnt=%b to=%b, want gnt=00001 to=0", i, gnt, timeout);
        errors++;
      end
    end
    req = 5'b00000;
    tick();
    checks++;
    if ({gnt, busy, timeout} !== 7'b0) begin
      $display("FAIL no_timeout_release: got gnt=%b busy=%b to=%b, want 0", gnt, busy, timeout);
      errors++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_grant();
    test_back_to_back();
    test_wrap();
    test_release();
    test_async_reset();
`ifdef RR_HOLD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
